// File: rtl/branch_pkg.sv
// branch_pkg: shared definitions for the branch resolution unit.
//   - funct3 encodings for the conditional branch types (BEQ..BGEU)
//   - resolve FSM state encoding
//   - counter width for the post-redirect flush timer
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam int unsigned FLUSH_CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/branch_taken_dec.sv
// branch_taken_dec: combinational taken/illegal decode for conditional branches.
// Ports:
//   funct3        in  branch type
//   eq..geu       in  condition flags from the condition generator
//   br_taken      out branch condition holds (0 for illegal encodings)
//   br_illegal    out funct3 is not a valid branch encoding (010/011)
module branch_taken_dec
    import branch_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       eq,
    input  logic       ne,
    input  logic       lt,
    input  logic       ge,
    input  logic       ltu,
    input  logic       geu,
    output logic       br_taken,
    output logic       br_illegal
);

    always_comb begin
        br_taken   = 1'b0;
        br_illegal = 1'b0;
        case (funct3)
            F3_BEQ:  br_taken = eq;
            F3_BNE:  br_taken = ne;
            F3_BLT:  br_taken = lt;
            F3_BGE:  br_taken = ge;
            F3_BLTU: br_taken = ltu;
            F3_BGEU: br_taken = geu;
            default: br_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: resolves branch/jal/jalr, issues a redirect to fetch and
// holds flush for FLUSH_CYCLES cycles once the redirect is accepted.
// Optional build macro: BRANCH_STATS_EN adds taken/not-taken branch counters.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid / in_ready     request handshake (ready only in IDLE)
//   is_branch/is_jal/is_jalr, funct3, pc, imm, rs1, eq..geu   request payload
//   redir_valid/redir_ready/redir_pc                          redirect handshake
//   flush                   kill younger instructions
//   misalign, illegal       one-cycle error pulses
//   taken_cnt, nottaken_cnt (BRANCH_STATS_EN only) branch outcome counters
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a request; not-taken/error requests stay here
// HOLD  | redirect presented, waiting for redir_ready
// FLUSH | flush asserted, down-counter running to terminal count 0
module branch_resolve
    import branch_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        is_branch,
    input  logic        is_jal,
    input  logic        is_jalr,
    input  logic [2:0]  funct3,
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic [31:0] rs1,
    input  logic        eq,
    input  logic        ne,
    input  logic        lt,
    input  logic        ge,
    input  logic        ltu,
    input  logic        geu,
    output logic        redir_valid,
    input  logic        redir_ready,
    output logic [31:0] redir_pc,
    output logic        flush,
    output logic        misalign,
`ifdef BRANCH_STATS_EN
    output logic        illegal,
    output logic [31:0] taken_cnt,
    output logic [31:0] nottaken_cnt
`else
    output logic        illegal
`endif
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]            redir_pc_q, redir_pc_d;
    logic                   misalign_q, misalign_d;
    logic                   illegal_q, illegal_d;

    logic        br_taken, br_illegal;
    logic        accept;
    logic        sel_jalr, sel_jal, sel_br;
    logic        taken;
    logic [31:0] base, sum, target;

    branch_taken_dec u_dec (
        .funct3     (funct3),
        .eq         (eq),
        .ne         (ne),
        .lt         (lt),
        .ge         (ge),
        .ltu        (ltu),
        .geu        (geu),
        .br_taken   (br_taken),
        .br_illegal (br_illegal)
    );

    // Request classification with priority jalr > jal > branch.
    always_comb begin
        accept   = in_valid && (state_q == ST_IDLE);
        sel_jalr = is_jalr;
        sel_jal  = is_jal && !is_jalr;
        sel_br   = is_branch && !is_jal && !is_jalr;
        taken    = sel_jalr || sel_jal || (sel_br && br_taken);
        base     = sel_jalr ? rs1 : pc;
        sum      = base + imm;
        target   = sel_jalr ? {sum[31:1], 1'b0} : sum;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        redir_pc_d = redir_pc_q;
        misalign_d = 1'b0;
        illegal_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    illegal_d = sel_br && br_illegal;
                    if (taken) begin
                        // Target is latched even when misaligned so the
                        // faulting address is visible alongside the pulse.
                        redir_pc_d = target;
                        if (target[1:0] != 2'b00) begin
                            misalign_d = 1'b1;
                        end else begin
                            state_d = ST_HOLD;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (redir_ready) begin
                    state_d = ST_FLUSH;
                    cnt_d   = FLUSH_LOAD;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            redir_pc_q <= '0;
            misalign_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            redir_pc_q <= redir_pc_d;
            misalign_q <= misalign_d;
            illegal_q  <= illegal_d;
        end
    end

    always_comb begin
        in_ready    = (state_q == ST_IDLE);
        redir_valid = (state_q == ST_HOLD);
        flush       = (state_q == ST_FLUSH);
        redir_pc    = redir_pc_q;
        misalign    = misalign_q;
        illegal     = illegal_q;
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] taken_cnt_q, taken_cnt_d;
    logic [31:0] nottaken_cnt_q, nottaken_cnt_d;

    // Only conditional branches with a legal funct3 are counted.
    always_comb begin
        taken_cnt_d    = taken_cnt_q;
        nottaken_cnt_d = nottaken_cnt_q;
        if (accept && sel_br && !br_illegal) begin
            if (br_taken) begin
                taken_cnt_d = taken_cnt_q + 32'd1;
            end else begin
                nottaken_cnt_d = nottaken_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            taken_cnt_q    <= '0;
            nottaken_cnt_q <= '0;
        end else begin
            taken_cnt_q    <= taken_cnt_d;
            nottaken_cnt_q <= nottaken_cnt_d;
        end
    end

    assign taken_cnt    = taken_cnt_q;
    assign nottaken_cnt = nottaken_cnt_q;
`endif

endmodule
